// File: rtl/word_serializer_if.sv
// Parallel-word handshake between a word producer and the serializer.
// The producer drives the word and its valid flag; the serializer returns ready.
interface word_serializer_if #(
    parameter int WORD_W = 12
);
    logic [WORD_W-1:0] iData;
    logic              iValid;
    logic              oReady;

    modport master (output iData, output iValid, input oReady);
    modport slave  (input iData, input iValid, output oReady);
endinterface

// File: rtl/word_serializer.sv
// MSB-first serial word transmitter paced by a divided bit clock sampled as data,
// with a frame strobe and a fixed idle gap after every word.
module word_serializer #(
    parameter int WORD_W   = 12,
    parameter int GAP_BITS = 2
) (
    input  logic             iClkIN,
    input  logic             reset,
    input  logic             iBitClk,
    word_serializer_if.slave hs,
    output logic             oSerial,
    output logic             oFrame,
    output logic             oBusy,
    output logic             oDone
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_BITS - 1);

    typedef enum logic [1:0] {IDLE, ARM, SHIFT, GAP} state_t;

    state_t             state_reg, state_next;
    logic               b1_reg, b2_reg;
    logic               tick, accept;
    logic [WORD_W-1:0]  shreg_reg, shreg_next;
    logic [CNT_W-1:0]   bitcnt_reg, bitcnt_next;
    logic [3:0]         gapcnt_reg, gapcnt_next;
    logic               serial_reg, serial_next;
    logic               frame_reg, frame_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               ready_reg, ready_next;

    // Rising-edge detect on the bit clock gives one system-clock tick per bit period
    assign tick   = b1_reg & ~b2_reg;
    assign accept = hs.iValid & ready_reg;

    always_ff @(posedge iClkIN) begin
        if (!reset) begin
            state_reg  <= IDLE;
            b1_reg     <= 1'b0;
            b2_reg     <= 1'b0;
            shreg_reg  <= '0;
            bitcnt_reg <= '0;
            gapcnt_reg <= '0;
            serial_reg <= 1'b0;
            frame_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            ready_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            b1_reg     <= iBitClk;
            b2_reg     <= b1_reg;
            shreg_reg  <= shreg_next;
            bitcnt_reg <= bitcnt_next;
            gapcnt_reg <= gapcnt_next;
            serial_reg <= serial_next;
            frame_reg  <= frame_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            ready_reg  <= ready_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        shreg_next  = shreg_reg;
        bitcnt_next = bitcnt_reg;
        gapcnt_next = gapcnt_reg;
        serial_next = serial_reg;
        frame_next  = frame_reg;
        busy_next   = busy_reg;
        ready_next  = ready_reg;
        done_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_next  = 1'b1;
                busy_next   = 1'b0;
                serial_next = 1'b0;
                frame_next  = 1'b0;
                if (accept) begin
                    shreg_next = hs.iData;
                    state_next = ARM;
                    ready_next = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            // Waiting for a fresh tick keeps the first bit a full period long
            ARM: begin
                if (tick) begin
                    state_next  = SHIFT;
                    serial_next = shreg_reg[WORD_W-1];
                    frame_next  = 1'b1;
                    shreg_next  = {shreg_reg[WORD_W-2:0], 1'b0};
                    bitcnt_next = BIT_LAST;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (bitcnt_reg != '0) begin
                        serial_next = shreg_reg[WORD_W-1];
                        shreg_next  = {shreg_reg[WORD_W-2:0], 1'b0};
                        bitcnt_next = bitcnt_reg - 1'b1;
                    end else begin
                        state_next  = GAP;
                        serial_next = 1'b0;
                        frame_next  = 1'b0;
                        gapcnt_next = GAP_LAST;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gapcnt_reg != 4'd0) begin
                        gapcnt_next = gapcnt_reg - 4'd1;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        ready_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign hs.oReady = ready_reg;
    assign oSerial   = serial_reg;
    assign oFrame    = frame_reg;
    assign oBusy     = busy_reg;
    assign oDone     = done_reg;
endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: WORD_W=12, GAP_BITS=2, bit clock period 8.
// Bits are also collected at each bit-clock fall, mid-bit, independent of timing.
module tb_word_serializer;
    logic iClkIN = 1'b0;
    logic reset  = 1'b0;
    logic iBitClk = 1'b0;
    logic oSerial, oFrame, oBusy, oDone;

    int n_vec = 0;
    int n_err = 0;

    logic       stall = 1'b0;
    logic [2:0] phase = 3'd0;
    bit         q[$];

    word_serializer_if #(.WORD_W(12)) hs();

    word_serializer #(.WORD_W(12), .GAP_BITS(2)) dut (
        .iClkIN (iClkIN),
        .reset  (reset),
        .iBitClk(iBitClk),
        .hs     (hs),
        .oSerial(oSerial),
        .oFrame (oFrame),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    initial forever #5 iClkIN = ~iClkIN;

    // Bit clock: 4 cycles high, 4 low; sample the line on each falling edge
    initial forever begin
        @(negedge iClkIN);
        if (!stall) begin
            phase = phase + 3'd1;
            if (iBitClk && !phase[2] && oFrame)
                q.push_back(oSerial);
            iBitClk = phase[2];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge iClkIN);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!hs.oReady && k < 200) begin
            @(negedge iClkIN);
            k++;
        end
        check("ready_timeout", {31'd0, hs.oReady}, 32'd1);
    endtask

    task automatic accept_word(input logic [11:0] w);
        wait_ready();
        hs.iData  = w;
        hs.iValid = 1'b1;
        @(negedge iClkIN);
        hs.iValid = 1'b0;
        $display("accept %03h", w);
        check("accept_busy", {31'd0, oBusy}, 32'd1);
        check("accept_ready", {31'd0, hs.oReady}, 32'd0);
        check("accept_noframe", {31'd0, oFrame}, 32'd0);
    endtask

    task automatic wait_frame_rise(output int k);
        k = 0;
        while (!oFrame && k < 40) begin
            @(negedge iClkIN);
            k++;
        end
        check("frame_rise_timeout", {31'd0, oFrame}, 32'd1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!oDone && k < 1000) begin
            @(negedge iClkIN);
            k++;
        end
        check("done_timeout", {31'd0, oDone}, 32'd1);
    endtask

    // Entered on the first cycle oFrame is visible; leaves on the oDone cycle
    task automatic check_frame(input logic [11:0] w);
        logic frame_bad = 1'b0;
        logic done_early = 1'b0;
        for (int c = 0; c < 96; c++) begin
            check("serial_bit", {31'd0, oSerial}, {31'd0, w[11 - c/8]});
            if (!oFrame) frame_bad = 1'b1;
            @(negedge iClkIN);
        end
        check("frame_high_96", {31'd0, frame_bad}, 32'd0);
        check("frame_fall", {31'd0, oFrame}, 32'd0);
        check("gap_serial", {31'd0, oSerial}, 32'd0);
        repeat (15) begin
            @(negedge iClkIN);
            if (oDone) done_early = 1'b1;
        end
        check("done_early", {31'd0, done_early}, 32'd0);
        @(negedge iClkIN);
        check("done_pulse", {31'd0, oDone}, 32'd1);
        check("done_ready", {31'd0, hs.oReady}, 32'd1);
        check("done_busy", {31'd0, oBusy}, 32'd0);
        $display("frame %03h checked", w);
    endtask

    task automatic check_bits(input logic [11:0] w);
        logic [11:0] v = '0;
        check("bit_count", q.size(), 32'd12);
        foreach (q[i]) v = {v[10:0], q[i]};
        check("bits", {20'd0, v}, {20'd0, w});
        $display("collected %03h", v);
    endtask

    initial begin
        int k;
        logic s;
        logic bad;
        logic seen_done;
        logic seen_frame;

        hs.iData  = 12'h000;
        hs.iValid = 1'b1;

        // Reset held with valid asserted and bit clock running
        repeat (5) begin
            @(negedge iClkIN);
            check("rst_outputs", {27'd0, oSerial, oFrame, oBusy, oDone, hs.oReady}, 32'd0);
        end
        reset = 1'b1;
        @(negedge iClkIN);
        hs.iValid = 1'b0;
        check("rst_exit_ready", {31'd0, hs.oReady}, 32'd1);
        check("rst_exit_busy", {31'd0, oBusy}, 32'd0);

        // Single word
        q.delete();
        accept_word(12'hA5C);
        wait_frame_rise(k);
        check_frame(12'hA5C);
        check_bits(12'hA5C);

        // Back-to-back with valid held high
        wait_ready();
        q.delete();
        hs.iData  = 12'h001;
        hs.iValid = 1'b1;
        @(negedge iClkIN);
        hs.iData = 12'hFFF;
        check("b2b_first_busy", {31'd0, oBusy}, 32'd1);
        wait_frame_rise(k);
        check_frame(12'h001);
        check_bits(12'h001);
        q.delete();
        @(negedge iClkIN);
        hs.iValid = 1'b0;
        check("b2b_accept_ready", {31'd0, hs.oReady}, 32'd0);
        check("b2b_accept_busy", {31'd0, oBusy}, 32'd1);
        wait_frame_rise(k);
        check("b2b_align", k, 32'd7);
        check_frame(12'hFFF);
        check_bits(12'hFFF);

        // Reset pulse in the middle of data bit 5
        accept_word(12'hA5C);
        wait_frame_rise(k);
        tick_n(5 * 8 + 3);
        reset = 1'b0;
        @(negedge iClkIN);
        check("midrst_outputs", {27'd0, oSerial, oFrame, oBusy, oDone, hs.oReady}, 32'd0);
        reset = 1'b1;
        @(negedge iClkIN);
        check("midrst_ready", {31'd0, hs.oReady}, 32'd1);
        seen_done  = 1'b0;
        seen_frame = 1'b0;
        repeat (150) begin
            @(negedge iClkIN);
            if (oDone) seen_done = 1'b1;
            if (oFrame) seen_frame = 1'b1;
        end
        check("midrst_no_done", {31'd0, seen_done}, 32'd0);
        check("midrst_no_frame", {31'd0, seen_frame}, 32'd0);
        $display("reset mid-frame checked");

        // Bit clock frozen high during the data bits
        q.delete();
        accept_word(12'h5A3);
        wait_frame_rise(k);
        tick_n(30);
        k = 0;
        while (phase != 3'd6 && k < 16) begin
            @(negedge iClkIN);
            k++;
        end
        check("stall_phase_timeout", {29'd0, phase}, 32'd6);
        stall = 1'b1;
        s = oSerial;
        bad = 1'b0;
        repeat (200) begin
            @(negedge iClkIN);
            if (oSerial !== s) bad = 1'b1;
        end
        check("stall_serial", {31'd0, bad}, 32'd0);
        check("stall_frame", {31'd0, oFrame}, 32'd1);
        check("stall_busy", {31'd0, oBusy}, 32'd1);
        stall = 1'b0;
        wait_done();
        check_bits(12'h5A3);

        // Valid pulsed while shifting must be ignored
        q.delete();
        accept_word(12'h3C6);
        wait_frame_rise(k);
        tick_n(20);
        hs.iData  = 12'h123;
        hs.iValid = 1'b1;
        tick_n(4);
        check("guard_ready", {31'd0, hs.oReady}, 32'd0);
        hs.iValid = 1'b0;
        wait_done();
        check_bits(12'h3C6);
        seen_frame = 1'b0;
        repeat (100) begin
            @(negedge iClkIN);
            if (oFrame) seen_frame = 1'b1;
        end
        check("guard_no_retx", {31'd0, seen_frame}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
